// File: rtl/mux_n_reg.sv
// N-input registered selector with valid/ready handshakes on every input and the output.
// Mode 0 selects the channel named by sel; mode 1 round-robins among the valid channels.
module mux_n_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic                         mode,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]         out_src,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [DATA_WIDTH-1:0] out_data_r;
  logic [SEL_WIDTH-1:0]  out_src_r;
  logic                  out_valid_r;
  logic [SEL_WIDTH-1:0]  rr_ptr_r;

  logic                  load_en_s;
  logic                  grant_vld_s;
  logic [SEL_WIDTH-1:0]  grant_idx_s;
  logic                  xfer_s;
  logic [DATA_WIDTH-1:0] grant_data_s;
  logic [NUM_IN-1:0]     in_ready_s;

  assign load_en_s = !out_valid_r || out_ready;
  assign xfer_s    = rst_n && load_en_s && grant_vld_s;

  // Grant selection: explicit sel in mode 0, rotating priority after rr_ptr in mode 1.
  always_comb begin
    int idx_v;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    idx_v       = 0;
    if (mode == 1'b0) begin
      // Comparing against every legal index keeps an out-of-range sel from ever granting.
      for (int i = 0; i < NUM_IN; i++) begin
        if ((sel == i[SEL_WIDTH-1:0]) && in_valid[i]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = i[SEL_WIDTH-1:0];
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end else begin
      // Offsets 1..NUM_IN visit rr_ptr+1 first and rr_ptr itself last.
      for (int off = 1; off <= NUM_IN; off++) begin
        idx_v = (int'(rr_ptr_r) + off) % NUM_IN;
        if (!grant_vld_s && in_valid[idx_v]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = idx_v[SEL_WIDTH-1:0];
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end
  end

  // Ready fan-out and data selection for the granted channel.
  always_comb begin
    in_ready_s   = '0;
    grant_data_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx_s == i[SEL_WIDTH-1:0]) begin
        in_ready_s[i] = xfer_s;
        grant_data_s  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        in_ready_s[i] = 1'b0;
      end
    end
  end

  assign in_ready = in_ready_s;

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_src_r   <= '0;
      out_valid_r <= 1'b0;
      rr_ptr_r    <= SEL_WIDTH'(NUM_IN - 1);
    end else if (xfer_s) begin
      out_data_r  <= grant_data_s;
      out_src_r   <= grant_idx_s;
      out_valid_r <= 1'b1;
      rr_ptr_r    <= grant_idx_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_src   = out_src_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed table-driven bench for mux_n_reg: a 4-input instance for the main
// behaviour and a 3-input instance for the out-of-range select and wrap boundary.
module tb_mux_n_reg;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_data4;
  logic [3:0]   in_valid4;
  logic [3:0]   in_ready4;
  logic [1:0]   sel4;
  logic         mode4;
  logic [31:0]  out_data4;
  logic [1:0]   out_src4;
  logic         out_valid4;
  logic         out_ready4;

  logic [95:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [1:0]   sel3;
  logic         mode3;
  logic [31:0]  out_data3;
  logic [1:0]   out_src3;
  logic         out_valid3;
  logic         out_ready3;

  int n_cmp;
  int n_bad;

  mux_n_reg #(.DATA_WIDTH(32), .NUM_IN(4), .SEL_WIDTH(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .sel(sel4), .mode(mode4), .out_data(out_data4),
    .out_src(out_src4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  mux_n_reg #(.DATA_WIDTH(32), .NUM_IN(3), .SEL_WIDTH(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] chan_word(input logic [1:0] idx);
    case (idx)
      2'd0:    chan_word = 32'h0000_1234;
      2'd1:    chan_word = 32'h1111_0001;
      2'd2:    chan_word = 32'hDEAD_BEEF;
      2'd3:    chan_word = 32'h3333_0003;
      default: chan_word = 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_src;
  } vec_t;

  vec_t vecs[22];
  logic [1:0] rr3_exp[4];
  logic [2:0] rdy3_exp[4];

  initial begin
    // round-robin over all four, from reset pointer
    vecs[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    // sparse requesters 1 and 3 alternate
    vecs[6]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    // explicit select, then select of an idle channel drains the output
    vecs[10] = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[11] = '{1'b0, 2'd1, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2};
    vecs[12] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd2};
    // load 32'h1234 then stall three cycles
    vecs[13] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[14] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[15] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[16] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0};
    // drain and replace in the same cycle, no bubble
    vecs[17] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[18] = '{1'b1, 2'd0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[19] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[20] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
    vecs[21] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};

    rr3_exp[0] = 2'd0; rr3_exp[1] = 2'd2; rr3_exp[2] = 2'd0; rr3_exp[3] = 2'd2;
    rdy3_exp[0] = 3'b001; rdy3_exp[1] = 3'b100; rdy3_exp[2] = 3'b001; rdy3_exp[3] = 3'b100;

    n_cmp = 0;
    n_bad = 0;
    in_data4   = {chan_word(2'd3), chan_word(2'd2), chan_word(2'd1), chan_word(2'd0)};
    in_data3   = {chan_word(2'd2), chan_word(2'd1), chan_word(2'd0)};
    rst_n      = 1'b0;
    in_valid4  = 4'b1111;
    sel4       = 2'd0;
    mode4      = 1'b1;
    out_ready4 = 1'b1;
    in_valid3  = 3'b000;
    sel3       = 2'd0;
    mode3      = 1'b0;
    out_ready3 = 1'b1;

    #12;
    chk("reset_out_valid", {63'd0, out_valid4}, 64'd0);
    chk("reset_out_data", {32'd0, out_data4}, 64'd0);
    chk("reset_out_src", {62'd0, out_src4}, 64'd0);
    chk("reset_in_ready", {60'd0, in_ready4}, 64'd0);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 22; v++) begin
      mode4      = vecs[v].mode;
      sel4       = vecs[v].sel;
      in_valid4  = vecs[v].vld;
      out_ready4 = vecs[v].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", v), {60'd0, in_ready4}, {60'd0, vecs[v].exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", v), {63'd0, out_valid4}, {63'd0, vecs[v].exp_ov});
      chk($sformatf("v%0d_out_src", v), {62'd0, out_src4}, {62'd0, vecs[v].exp_src});
      chk($sformatf("v%0d_out_data", v), {32'd0, out_data4}, {32'd0, chan_word(vecs[v].exp_src)});
    end

    // Stall with a held word, then reset between clock edges.
    mode4      = 1'b1;
    in_valid4  = 4'b1111;
    out_ready4 = 1'b0;
    #1;
    chk("stall_load_in_ready", {60'd0, in_ready4}, {60'd0, 4'b1000});
    @(posedge clk);
    #1;
    chk("stall_out_valid", {63'd0, out_valid4}, 64'd1);
    chk("stall_out_src", {62'd0, out_src4}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {63'd0, out_valid4}, 64'd0);
    chk("async_rst_out_data", {32'd0, out_data4}, 64'd0);
    chk("async_rst_in_ready", {60'd0, in_ready4}, 64'd0);
    #1;
    rst_n      = 1'b1;
    out_ready4 = 1'b1;
    #1;
    chk("post_rst_in_ready", {60'd0, in_ready4}, {60'd0, 4'b0001});
    @(posedge clk);
    #1;
    chk("post_rst_out_src", {62'd0, out_src4}, 64'd0);
    chk("post_rst_out_valid", {63'd0, out_valid4}, 64'd1);
    chk("post_rst_out_data", {32'd0, out_data4}, {32'd0, chan_word(2'd0)});
    in_valid4 = 4'b0000;

    // Three-input instance: sel beyond the channel count never grants.
    mode3     = 1'b0;
    sel3      = 2'd3;
    in_valid3 = 3'b111;
    #1;
    chk("n3_sel3_in_ready", {61'd0, in_ready3}, 64'd0);
    @(posedge clk);
    #1;
    chk("n3_sel3_out_valid", {63'd0, out_valid3}, 64'd0);
    chk("n3_sel3_out_data", {32'd0, out_data3}, 64'd0);

    // Round-robin wraps from channel 2 back to 0.
    mode3     = 1'b1;
    in_valid3 = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("n3_rr%0d_in_ready", k), {61'd0, in_ready3}, {61'd0, rdy3_exp[k]});
      @(posedge clk);
      #1;
      chk($sformatf("n3_rr%0d_out_src", k), {62'd0, out_src3}, {62'd0, rr3_exp[k]});
      chk($sformatf("n3_rr%0d_out_data", k), {32'd0, out_data3}, {32'd0, chan_word(rr3_exp[k])});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
